fractal_dispatch_array: RTL and testbench



---
 rtl/fractal_dispatch_array.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_fractal_dispatch_array.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_dispatch_array.sv
// fractal_dispatch_array: a pool of escape-time fractal lanes behind one job stream and one
// result stream.
//
// Jobs are dispatched round-robin to idle lanes. Finished results are collected round-robin
// through a valid/ready output, and each result carries the tag of its job.
// Optional macro FRACTAL_STATS_EN adds saturating busy-cycle and delivered-job counters.
// When the macro is undefined, both stat ports read 0.
//
// Ports (fractal_dispatch_array):
//   clk_i, rst_i                     clock, synchronous active-high reset
//   job_valid_i / job_ready_o        job handshake (ready = some lane is idle)
//   job_mode_i                       0 = Mandelbrot, 1 = Julia
//   job_px_i, job_py_i               pixel coordinate (signed Q format)
//   job_cx_i, job_cy_i               Julia constant (ignored in Mandelbrot mode)
//   job_max_iter_i, job_tag_i        iteration limit, opaque tag
//   out_valid_o / out_ready_i        result handshake
//   out_iter_o, out_tag_o, out_lane_o  result payload
//   stat_busy_o, stat_jobs_o         performance counters
//
// Ports (juliaCore):
//   start_i loads operands; done_o pulses for one cycle; iter_o holds the final count.

module juliaCore #(
    parameter int unsigned INTEGER_BITS    = 8,
    parameter int unsigned FRACTIONAL_BITS = 24,
    parameter int unsigned MAX_ITER_WIDTH  = 16
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         start_i,
    input  logic signed [INTEGER_BITS+FRACTIONAL_BITS-1:0] cx_i,
    input  logic signed [INTEGER_BITS+FRACTIONAL_BITS-1:0] cy_i,
    input  logic signed [INTEGER_BITS+FRACTIONAL_BITS-1:0] zx_i,
    input  logic signed [INTEGER_BITS+FRACTIONAL_BITS-1:0] zy_i,
    input  logic        [MAX_ITER_WIDTH-1:0]              max_iter_i,
    output logic                                         done_o,
    output logic        [MAX_ITER_WIDTH-1:0]              iter_o
);
    localparam int unsigned DW = INTEGER_BITS + FRACTIONAL_BITS;
    // Full-precision products plus one guard bit so |z|^2 never overflows.
    localparam int unsigned PW = 2 * DW + 1;
    localparam logic signed [PW-1:0] ESC_LIMIT = PW'(4) <<< (2 * FRACTIONAL_BITS);

    logic                      r_busy, r_done;
    logic signed [DW-1:0]      r_zx, r_zy, r_cx, r_cy;
    logic [MAX_ITER_WIDTH-1:0] r_max, r_iter;

    logic signed [PW-1:0] w_zx_ext, w_zy_ext, w_xx, w_yy, w_xy, w_mag, w_diff, w_sh_re, w_sh_im;
    logic                 w_escape;

    assign w_zx_ext = PW'(r_zx);
    assign w_zy_ext = PW'(r_zy);
    assign w_xx     = w_zx_ext * w_zx_ext;
    assign w_yy     = w_zy_ext * w_zy_ext;
    assign w_xy     = w_zx_ext * w_zy_ext;
    assign w_mag    = w_xx + w_yy;
    assign w_diff   = w_xx - w_yy;
    assign w_sh_re  = w_diff >>> FRACTIONAL_BITS;
    // 2*x*y rescaled: one fewer fractional shift doubles the product exactly.
    assign w_sh_im  = w_xy >>> (FRACTIONAL_BITS - 1);
    assign w_escape = (w_mag > ESC_LIMIT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_iter <= '0;
            r_max  <= '0;
            r_zx   <= '0;
            r_zy   <= '0;
            r_cx   <= '0;
            r_cy   <= '0;
        end else begin
            r_done <= 1'b0;
            if (start_i) begin
                r_busy <= 1'b1;
                r_iter <= '0;
                r_max  <= max_iter_i;
                r_zx   <= zx_i;
                r_zy   <= zy_i;
                r_cx   <= cx_i;
                r_cy   <= cy_i;
            end else if (r_busy) begin
                // Termination is tested before the step, so a zero limit reports 0.
                if (w_escape || (r_iter == r_max)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end else begin
                    r_zx   <= w_sh_re[DW-1:0] + r_cx;
                    r_zy   <= w_sh_im[DW-1:0] + r_cy;
                    r_iter <= r_iter + 1'b1;
                end
            end
        end
    end

    assign done_o = r_done;
    assign iter_o = r_iter;
endmodule

module fractal_dispatch_array #(
    parameter int unsigned INTEGER_BITS    = 8,
    parameter int unsigned FRACTIONAL_BITS = 24,
    parameter int unsigned MAX_ITER_WIDTH  = 16,
    parameter int unsigned LANE_COUNT      = 4,
    parameter int unsigned TAG_WIDTH       = 20,
    parameter int unsigned STAT_WIDTH      = 32
) (
    input  logic                                           clk_i,
    input  logic                                           rst_i,
    input  logic                                           job_valid_i,
    output logic                                           job_ready_o,
    input  logic                                           job_mode_i,
    input  logic signed [INTEGER_BITS+FRACTIONAL_BITS-1:0] job_px_i,
    input  logic signed [INTEGER_BITS+FRACTIONAL_BITS-1:0] job_py_i,
    input  logic signed [INTEGER_BITS+FRACTIONAL_BITS-1:0] job_cx_i,
    input  logic signed [INTEGER_BITS+FRACTIONAL_BITS-1:0] job_cy_i,
    input  logic        [MAX_ITER_WIDTH-1:0]               job_max_iter_i,
    input  logic        [TAG_WIDTH-1:0]                    job_tag_i,
    output logic                                           out_valid_o,
    input  logic                                           out_ready_i,
    output logic        [MAX_ITER_WIDTH-1:0]               out_iter_o,
    output logic        [TAG_WIDTH-1:0]                    out_tag_o,
    output logic [((LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1)-1:0] out_lane_o,
    output logic        [STAT_WIDTH-1:0]                   stat_busy_o,
    output logic        [STAT_WIDTH-1:0]                   stat_jobs_o
);
    localparam int unsigned DW = INTEGER_BITS + FRACTIONAL_BITS;
    localparam int unsigned LW = (LANE_COUNT > 1) ? $clog2(LANE_COUNT) : 1;
    localparam int          NL = int'(LANE_COUNT);

    typedef enum logic [1:0] {StIdle, StStart, StRun, StDone} lane_state_e;

    lane_state_e               r_state    [LANE_COUNT];
    logic signed [DW-1:0]      r_cx       [LANE_COUNT];
    logic signed [DW-1:0]      r_cy       [LANE_COUNT];
    logic signed [DW-1:0]      r_zx       [LANE_COUNT];
    logic signed [DW-1:0]      r_zy       [LANE_COUNT];
    logic [MAX_ITER_WIDTH-1:0] r_max_iter [LANE_COUNT];
    logic [MAX_ITER_WIDTH-1:0] r_res_iter [LANE_COUNT];
    logic [TAG_WIDTH-1:0]      r_tag      [LANE_COUNT];
    logic [LW-1:0]             r_disp_ptr, r_col_ptr;

    logic                      w_core_start [LANE_COUNT];
    logic                      w_core_done  [LANE_COUNT];
    logic [MAX_ITER_WIDTH-1:0] w_core_iter  [LANE_COUNT];

    logic          w_disp_found, w_col_found, w_accept, w_handshake;
    logic [LW-1:0] w_disp_sel, w_col_sel;

    function automatic logic [LW-1:0] wrap_add(input logic [LW-1:0] base, input int inc);
        int sum;
        sum = int'(base) + inc;
        return LW'(sum % NL);
    endfunction

    // Round-robin search; both selections depend only on registered state.
    always_comb begin
        w_disp_found = 1'b0;
        w_disp_sel   = '0;
        w_col_found  = 1'b0;
        w_col_sel    = '0;
        for (int k = 0; k < NL; k++) begin
            if (!w_disp_found && r_state[wrap_add(r_disp_ptr, k)] == StIdle) begin
                w_disp_found = 1'b1;
                w_disp_sel   = wrap_add(r_disp_ptr, k);
            end
            if (!w_col_found && r_state[wrap_add(r_col_ptr, k)] == StDone) begin
                w_col_found = 1'b1;
                w_col_sel   = wrap_add(r_col_ptr, k);
            end
        end
    end

    assign job_ready_o = w_disp_found;
    assign w_accept    = job_valid_i & w_disp_found;
    assign w_handshake = w_col_found & out_ready_i;
    assign out_valid_o = w_col_found;
    assign out_iter_o  = w_col_found ? r_res_iter[w_col_sel] : '0;
    assign out_tag_o   = w_col_found ? r_tag[w_col_sel] : '0;
    assign out_lane_o  = w_col_found ? w_col_sel : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NL; i++) begin
                r_state[i] <= StIdle;
            end
            r_disp_ptr <= '0;
            r_col_ptr  <= '0;
        end else begin
            for (int i = 0; i < NL; i++) begin
                unique case (r_state[i])
                    StIdle: begin
                        if (w_accept && w_disp_sel == LW'(i)) begin
                            r_state[i]    <= StStart;
                            r_cx[i]       <= job_mode_i ? job_cx_i : job_px_i;
                            r_cy[i]       <= job_mode_i ? job_cy_i : job_py_i;
                            r_zx[i]       <= job_mode_i ? job_px_i : '0;
                            r_zy[i]       <= job_mode_i ? job_py_i : '0;
                            r_max_iter[i] <= job_max_iter_i;
                            r_tag[i]      <= job_tag_i;
                        end
                    end
                    StStart: r_state[i] <= StRun;
                    StRun: begin
                        if (w_core_done[i]) begin
                            r_res_iter[i] <= w_core_iter[i];
                            r_state[i]    <= StDone;
                        end
                    end
                    StDone: begin
                        if (w_handshake && w_col_sel == LW'(i)) begin
                            r_state[i] <= StIdle;
                        end
                    end
                    default: r_state[i] <= StIdle;
                endcase
            end
            if (w_accept) begin
                r_disp_ptr <= wrap_add(w_disp_sel, 1);
            end
            // A stalled result pins the pointer to its lane so a lane finishing later
            // cannot overtake it and change out_* while valid is held.
            if (w_handshake) begin
                r_col_ptr <= wrap_add(w_col_sel, 1);
            end else if (w_col_found) begin
                r_col_ptr <= w_col_sel;
            end
        end
    end

    for (genvar g = 0; g < NL; g++) begin : g_lane
        assign w_core_start[g] = (r_state[g] == StStart);
        juliaCore #(
            .INTEGER_BITS    (INTEGER_BITS),
            .FRACTIONAL_BITS (FRACTIONAL_BITS),
            .MAX_ITER_WIDTH  (MAX_ITER_WIDTH)
        ) u_core (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .start_i    (w_core_start[g]),
            .cx_i       (r_cx[g]),
            .cy_i       (r_cy[g]),
            .zx_i       (r_zx[g]),
            .zy_i       (r_zy[g]),
            .max_iter_i (r_max_iter[g]),
            .done_o     (w_core_done[g]),
            .iter_o     (w_core_iter[g])
        );
    end

`ifdef FRACTAL_STATS_EN
    logic                  w_any_busy;
    logic [STAT_WIDTH-1:0] r_stat_busy, r_stat_jobs;

    always_comb begin
        w_any_busy = 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (r_state[i] != StIdle) begin
                w_any_busy = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stat_busy <= '0;
            r_stat_jobs <= '0;
        end else begin
            if (w_any_busy && r_stat_busy != '1) begin
                r_stat_busy <= r_stat_busy + 1'b1;
            end
            if (w_handshake && r_stat_jobs != '1) begin
                r_stat_jobs <= r_stat_jobs + 1'b1;
            end
        end
    end

    assign stat_busy_o = r_stat_busy;
    assign stat_jobs_o = r_stat_jobs;
`else
    assign stat_busy_o = '0;
    assign stat_jobs_o = '0;
`endif
endmodule

// File: tb/tb_fractal_dispatch_array.sv
// Scoreboard bench for fractal_dispatch_array (LANE_COUNT = 4, Q8.24).
module tb_fractal_dispatch_array;
    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic               job_valid = 1'b0;
    logic               job_ready_o;
    logic               job_mode = 1'b0;
    logic signed [31:0] job_px = '0, job_py = '0, job_cx = '0, job_cy = '0;
    logic [15:0]        job_max_iter = '0;
    logic [19:0]        job_tag = '0;
    logic               out_valid_o;
    logic               out_ready = 1'b0;
    logic [15:0]        out_iter_o;
    logic [19:0]        out_tag_o;
    logic [1:0]         out_lane_o;
    logic [31:0]        stat_busy_o, stat_jobs_o;

    always #5 clk = ~clk;

    fractal_dispatch_array dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .job_valid_i    (job_valid),
        .job_ready_o    (job_ready_o),
        .job_mode_i     (job_mode),
        .job_px_i       (job_px),
        .job_py_i       (job_py),
        .job_cx_i       (job_cx),
        .job_cy_i       (job_cy),
        .job_max_iter_i (job_max_iter),
        .job_tag_i      (job_tag),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready),
        .out_iter_o     (out_iter_o),
        .out_tag_o      (out_tag_o),
        .out_lane_o     (out_lane_o),
        .stat_busy_o    (stat_busy_o),
        .stat_jobs_o    (stat_jobs_o)
    );

    typedef struct {
        int tag;
        int iter;
        int lane;
    } exp_t;

    exp_t sb[$];
    int   got[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   hs_count = 0;
    int   hs_cyc = 0;
    bit   rand_ready = 1'b0;
    bit   ready_req = 1'b0;
    bit   t4_done = 1'b0;
    int   t4_acc = -1;
    int   outst = 0;
    int   busy_m = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_req;
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Bit-accurate escape-time reference in Q8.24.
    function automatic int golden(input bit mode, input logic signed [31:0] px, py, jcx, jcy,
                                  input int mi);
        logic signed [31:0] zx, zy, cx, cy;
        logic signed [64:0] ex, ey, xx, yy, xy, lim, d, s1, s2;
        int n;
        if (mode) begin cx = jcx; cy = jcy; zx = px; zy = py; end
        else begin cx = px; cy = py; zx = '0; zy = '0; end
        lim = 65'sd4 <<< 48;
        n = 0;
        while (n != mi) begin
            ex = 65'(zx);
            ey = 65'(zy);
            xx = ex * ex;
            yy = ey * ey;
            xy = ex * ey;
            if (xx + yy > lim) return n;
            d  = xx - yy;
            s1 = d >>> 24;
            s2 = xy >>> 23;
            zx = s1[31:0] + cx;
            zy = s2[31:0] + cy;
            n++;
        end
        return n;
    endfunction

    // Monitor: pops on every output handshake, and checks stability while stalled.
    bit          prev_stall = 1'b0;
    logic [15:0] p_iter;
    logic [19:0] p_tag;
    logic [1:0]  p_lane;
    always @(negedge clk) begin
        if (rst_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!out_valid_o || out_iter_o != p_iter || out_tag_o != p_tag ||
                    out_lane_o != p_lane) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%0b it=%0d tag=%0d lane=%0d expected v=1 it=%0d tag=%0d lane=%0d",
                             out_valid_o, out_iter_o, out_tag_o, out_lane_o, p_iter, p_tag, p_lane);
                end
            end
            if (out_valid_o && out_ready) begin
                int idx;
                idx = -1;
                foreach (sb[i]) if (idx < 0 && sb[i].tag == int'(out_tag_o)) idx = i;
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL unexpected_tag: got tag %0d expected a pending tag", out_tag_o);
                end else begin
                    check($sformatf("iter_tag%0d", out_tag_o), out_iter_o, sb[idx].iter);
                    if (sb[idx].lane >= 0)
                        check($sformatf("lane_tag%0d", out_tag_o), out_lane_o, sb[idx].lane);
                    sb.delete(idx);
                end
                got.push_back(int'(out_tag_o));
                hs_count++;
                hs_cyc = cyc;
            end
            prev_stall = out_valid_o && !out_ready;
            p_iter = out_iter_o;
            p_tag  = out_tag_o;
            p_lane = out_lane_o;
        end
    end

    // Busy-cycle model: a cycle is busy when any accepted job is still undelivered.
    always @(negedge clk) begin
        if (rst_i) begin
            outst  = 0;
            busy_m = 0;
        end else begin
            if (outst > 0) busy_m++;
            if (job_valid && job_ready_o) outst++;
            if (out_valid_o && out_ready) outst--;
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send_job(input bit mode, input logic signed [31:0] px, py, cx, cy,
                            input int mi, input int tag, input int exp_iter, input int exp_lane,
                            output int acc_cyc);
        int  waited;
        bit  done;
        exp_t e;
        waited = 0;
        done = 1'b0;
        acc_cyc = -1;
        job_valid = 1'b1;
        job_mode = mode;
        job_px = px;
        job_py = py;
        job_cx = cx;
        job_cy = cy;
        job_max_iter = 16'(mi);
        job_tag = 20'(tag);
        while (!done) begin
            @(negedge clk);
            if (job_ready_o && !rst_i) begin
                e.tag = tag;
                e.iter = exp_iter;
                e.lane = exp_lane;
                sb.push_back(e);
                acc_cyc = cyc;
                done = 1'b1;
            end else if (++waited > 1000) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got no accept for tag %0d expected accept", tag);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        job_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        job_valid = 1'b0;
        sb.delete();
        got.delete();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n;
        logic signed [31:0] a, b, c, d;
        bit m;
        int mi;

        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("rst_job_ready", job_ready_o, 1);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_out_iter", out_iter_o, 0);
        check("rst_out_tag", out_tag_o, 0);
        check("rst_out_lane", out_lane_o, 0);
        check("rst_stat_busy", stat_busy_o, 0);
        check("rst_stat_jobs", stat_jobs_o, 0);

        // Single Mandelbrot job at the origin never escapes.
        @(posedge clk);
        #1;
        ready_req = 1'b1;
        send_job(1'b0, 0, 0, 0, 0, 64, 5, 64, 0, acc);
        n = 0;
        while (!dut.g_lane[0].u_core.done_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("t1_core_done_seen", dut.g_lane[0].u_core.done_o, 1);
        check("t1_valid_at_done", out_valid_o, 0);
        @(negedge clk);
        check("t1_valid_done_plus1", out_valid_o, 1);
        wait_drain(200);

        // Five back-to-back jobs with output stalled.
        ready_req = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) send_job(1'b0, 0, 0, 0, 0, 3, i, 3, i, acc);
        t4_done = 1'b0;
        fork
            begin
                send_job(1'b0, 0, 0, 0, 0, 3, 4, 3, 0, t4_acc);
                t4_done = 1'b1;
            end
        join_none
        repeat (15) @(negedge clk);
        check("t2_ready_low_full", job_ready_o, 0);
        check("t2_tag4_waiting", t4_done, 0);
        check("t2_first_out_tag", out_tag_o, 0);
        n = hs_count;
        ready_req = 1'b1;
        @(negedge clk);
        ready_req = 1'b0;
        @(negedge clk);
        check("t2_one_handshake", hs_count, n + 1);
        n = 0;
        while (!t4_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t2_tag4_accept_cycle", t4_acc, hs_cyc + 1);
        ready_req = 1'b1;
        wait_drain(200);
        check("t2_delivered", got.size(), 5);

        // Julia (-0.75 + 0i, z0 = 2) escapes after 1 step; Mandelbrot at 0 runs to the limit.
        do_reset();
        send_job(1'b1, 32'h0200_0000, 0, 32'hFF40_0000, 0, 100, 1, 1, 0, acc);
        send_job(1'b0, 0, 0, 0, 0, 100, 2, 100, 1, acc);
        wait_drain(400);
        check("t3_count", got.size(), 2);
        if (got.size() > 0) check("t3_julia_first", got[0], 1);

        // Random jobs under random backpressure.
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            m  = 1'($urandom_range(0, 1));
            a  = 32'($urandom_range(0, 32'h03FF_FFFF)) - 32'h0200_0000;
            b  = 32'($urandom_range(0, 32'h03FF_FFFF)) - 32'h0200_0000;
            c  = m ? 32'($urandom_range(0, 32'h03FF_FFFF)) - 32'h0200_0000 : 32'($urandom);
            d  = m ? 32'($urandom_range(0, 32'h03FF_FFFF)) - 32'h0200_0000 : 32'($urandom);
            mi = int'($urandom_range(0, 31));
            send_job(m, a, b, c, d, mi, 1000 + i, golden(m, a, b, c, d, mi), -1, acc);
        end
        wait_drain(20000);
        rand_ready = 1'b0;
        check("t4_all_returned", got.size(), 1000);

        // Reset with one lane DONE and three running.
        ready_req = 1'b0;
        do_reset();
        send_job(1'b0, 0, 0, 0, 0, 0, 900, 0, 0, acc);
        for (int i = 1; i < 4; i++) send_job(1'b0, 0, 0, 0, 0, 1000, 900 + i, 1000, i, acc);
        repeat (10) @(negedge clk);
        check("t5_done_presented", out_valid_o, 1);
        check("t5_done_tag", out_tag_o, 900);
        check("t5_ready_low", job_ready_o, 0);
        n = hs_count;
        @(posedge clk);
        #1;
        rst_i = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("t5_valid_cleared", out_valid_o, 0);
        check("t5_ready_high", job_ready_o, 1);
        check("t5_stat_busy_cleared", stat_busy_o, 0);
        check("t5_stat_jobs_cleared", stat_jobs_o, 0);
        ready_req = 1'b1;
        repeat (40) @(negedge clk);
        check("t5_no_stale", hs_count, n);

        // Ten jobs, zero limit included, for the counters.
        do_reset();
        for (int i = 0; i < 10; i++) send_job(1'b0, 0, 0, 0, 0, i, 2000 + i, i, -1, acc);
        wait_drain(400);
`ifdef FRACTAL_STATS_EN
        check("t6_stat_jobs", stat_jobs_o, 10);
        check("t6_stat_busy", stat_busy_o, busy_m);
`else
        check("t6_stat_jobs", stat_jobs_o, 0);
        check("t6_stat_busy", stat_busy_o, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
